accum_bank: RTL
===============

ACCUM_BANK -- requirements
Module: accum_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 32: signed input data width.
REQ-002 SHALL have parameter DEPTH, default 16: number of accumulator entries, at least 2.
REQ-003 SHALL have parameter GUARD, default 4: guard bits, so entry width ACC_W = WIDTH+GUARD and address width AW = $clog2(DEPTH) (both localparams).
REQ-004 SHALL have ports, one clock domain, reset synchronous and active-high:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous active-high reset.
- wr_op_i  in  2  NOP=00, ADD=01, SET=10, SUB=11.
- wr_addr_i  in  AW  write entry index.
- wr_data_i  in  WIDTH  signed write operand.
- wr_ready_o  out  1  write accepted this cycle when high.
- rd_en_i  in  1  read request.
- rd_addr_i  in  AW  read entry index.
- rd_data_o  out  ACC_W  signed read data.
- rd_valid_o  out  1  rd_data_o valid.
- clr_all_i  in  1  start a clear sweep.
- busy_o  out  1  clear sweep in progress.
- ovf_o  out  1  sticky overflow flag.

Function
REQ-005 SHALL accept a write when wr_op_i != NOP and wr_ready_o = 1, updating the entry at the next rising edge.
REQ-006 SHALL sign-extend wr_data_i to ACC_W before any arithmetic.
REQ-007 SHALL compute ADD as entry+data, SUB as entry-data and SET as data, all at ACC_W width.
REQ-008 SHALL ignore wr_addr_i values >= DEPTH (no update) and SHALL return 0 with rd_valid_o = 1 for out-of-range reads.
REQ-009 SHALL register reads with 1-cycle latency: rd_en_i at edge N gives rd_data_o/rd_valid_o after edge N.
REQ-010 SHALL drive rd_valid_o = 0 and rd_data_o = 0 in any cycle that follows a cycle with no accepted read.
REQ-011 SHALL return the pre-update value when a read and an accepted write target the same entry in the same cycle (read-before-write).
REQ-012 SHALL set ovf_o when an ADD/SUB result falls outside the signed ACC_W range.
REQ-013 SHALL keep ovf_o set until rst or the start of a clear sweep.
REQ-014 SHALL implement FSM states IDLE and CLEAR, with these transitions: IDLE->CLEAR on clr_all_i; CLEAR->IDLE after entry DEPTH-1 is zeroed.
REQ-015 SHALL, in CLEAR, zero one entry per cycle in ascending order from index 0, so the sweep lasts exactly DEPTH cycles.
REQ-016 SHALL drive busy_o = 1 in CLEAR and wr_ready_o = ~busy_o; writes presented while busy are dropped.
REQ-017 SHALL ignore rd_en_i while busy_o = 1 (rd_valid_o = 0 on the following cycle).
REQ-018 SHALL ignore clr_all_i while in CLEAR, with no restart.
REQ-019 SHALL give clr_all_i priority when it is asserted in IDLE together with a write: the write is dropped and the sweep starts.

Reset
REQ-020 SHALL, on rst, force rd_data_o = 0, rd_valid_o = 0 and ovf_o = 0, and set the sweep index to 0.
REQ-021 SHALL enter CLEAR when rst deasserts, so busy_o = 1 and wr_ready_o = 0 for DEPTH cycles, which initialises all entries without a reset fan-out on storage.
REQ-022 SHALL restart the sweep at index 0 if rst is asserted mid-sweep.

Configuration
REQ-023 SHALL provide macro ACCUM_SAT_EN.
REQ-024 SHALL, when ACCUM_SAT_EN is defined, clamp overflowing ADD/SUB results to +(2^(ACC_W-1))-1 or -2^(ACC_W-1) and still set ovf_o.
REQ-025 SHALL, when ACCUM_SAT_EN is undefined, wrap results modulo 2^ACC_W and set ovf_o.

Structure
REQ-026 SHALL place the op enum (NOP/ADD/SET/SUB) and the FSM state enum (IDLE/CLEAR) in shared package accum_pkg.
REQ-027 SHALL implement the arithmetic and overflow/saturation as sub-module accum_sat_add (combinational, parameter ACC_W).

Verification
REQ-028 SHALL include these directed scenarios:
- Reset then idle -> busy_o = 1 for exactly 16 cycles; afterwards a read of every entry returns 0.
- SET addr3 = 100, ADD addr3 = -30, read addr3 -> 70 one cycle after rd_en_i, rd_valid_o = 1.
- ADD addr5 = 5 with a same-cycle read of addr5 (holding 10) -> read returns 10; the next read returns 15.
- WIDTH = 8, GUARD = 0: SET 127 then ADD 1 -> with ACCUM_SAT_EN, 127 and ovf_o = 1; without it, -128 and ovf_o = 1.
- clr_all_i together with ADD addr0 = 9 -> write dropped, wr_ready_o = 0 for 16 cycles, ovf_o cleared, all entries 0.
- rst at cycle 5 of a sweep -> the sweep restarts at index 0 and busy_o lasts a further 16 cycles.

Source files
------------

// File: rtl/accum_pkg.sv
`default_nettype none
// ==== accum_pkg : shared op and state encodings for the accumulator bank  |  rev 1.0 ====
package accum_pkg;

  typedef enum logic [1:0] {
    NOP = 2'b00,
    ADD = 2'b01,
    SET = 2'b10,
    SUB = 2'b11
  } op_e;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/accum_sat_add.sv
`default_nettype none
// ==== accum_sat_add : ADD/SUB/SET datapath with overflow detect; saturates under ACCUM_SAT_EN  |  rev 1.0 ====
module accum_sat_add
  import accum_pkg::*;
#(
  parameter int ACC_W = 36
) (
  input  op_e              op,
  input  logic [ACC_W-1:0] entry,
  input  logic [ACC_W-1:0] operand,
  output logic [ACC_W-1:0] result,
  output logic             ovf
);

`ifdef ACCUM_SAT_EN
  localparam logic [ACC_W-1:0] MAX_VAL = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MIN_VAL = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  // One extra bit holds the exact result; its top two bits disagree on overflow.
  logic [ACC_W:0] ext;

  always_comb begin
    ext    = '0;
    result = operand;
    ovf    = 1'b0;
    case (op)
      ADD:     ext = {entry[ACC_W-1], entry} + {operand[ACC_W-1], operand};
      SUB:     ext = {entry[ACC_W-1], entry} - {operand[ACC_W-1], operand};
      default: ext = '0;
    endcase
    if (op == ADD || op == SUB) begin
      ovf = ext[ACC_W] ^ ext[ACC_W-1];
`ifdef ACCUM_SAT_EN
      result = ovf ? (ext[ACC_W] ? MIN_VAL : MAX_VAL) : ext[ACC_W-1:0];
`else
      result = ext[ACC_W-1:0];
`endif
    end
  end

endmodule
`default_nettype wire

// File: rtl/accum_bank.sv
`default_nettype none
// ==== accum_bank : bank of signed accumulators with registered reads and a clear sweep;  |  rev 1.0
// ==== define ACCUM_SAT_EN to saturate ADD/SUB overflow instead of wrapping ====
module accum_bank
  import accum_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 16,
  parameter  int GUARD = 4,
  localparam int ACC_W = WIDTH + GUARD,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       wr_op_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             wr_ready_o,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [ACC_W-1:0] rd_data_o,
  output logic             rd_valid_o,
  input  logic             clr_all_i,
  output logic             busy_o,
  output logic             ovf_o
);

  localparam logic [AW:0]   DEPTH_LIM = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

  state_e           state, state_next;
  logic [AW-1:0]    sweep_idx, sweep_idx_next;
  logic [ACC_W-1:0] mem [DEPTH];

  op_e              wr_op;
  logic             busy;
  logic             wr_in_range, rd_in_range;
  logic             wr_accept, rd_accept, clr_start;
  logic [ACC_W-1:0] data_ext, entry_cur, sum;
  logic             sum_ovf;

  assign wr_op       = op_e'(wr_op_i);
  assign wr_in_range = {1'b0, wr_addr_i} < DEPTH_LIM;
  assign rd_in_range = {1'b0, rd_addr_i} < DEPTH_LIM;

  // A clear request in IDLE wins over a same-cycle write.
  assign clr_start = !busy && clr_all_i;
  assign wr_accept = !busy && !clr_all_i && (wr_op != NOP) && wr_in_range;
  assign rd_accept = !busy && rd_en_i;

  assign data_ext  = ACC_W'($signed(wr_data_i));
  assign entry_cur = wr_in_range ? mem[wr_addr_i] : '0;

  accum_sat_add #(
    .ACC_W (ACC_W)
  ) u_sat_add (
    .op      (wr_op),
    .entry   (entry_cur),
    .operand (data_ext),
    .result  (sum),
    .ovf     (sum_ovf)
  );

  // Reset lands in CLEAR so the sweep initialises storage without a reset tree on it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      sweep_idx <= '0;
    end else begin
      state     <= state_next;
      sweep_idx <= sweep_idx_next;
    end
  end

  always_comb begin
    state_next     = state;
    sweep_idx_next = sweep_idx;
    busy           = 1'b0;
    case (state)
      IDLE: begin
        if (clr_all_i) begin
          state_next     = CLEAR;
          sweep_idx_next = '0;
        end
      end
      CLEAR: begin
        busy = 1'b1;
        if (sweep_idx == LAST_IDX) begin
          state_next     = IDLE;
          sweep_idx_next = '0;
        end else begin
          sweep_idx_next = sweep_idx + AW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy_o     = busy;
  assign wr_ready_o = ~busy;

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (busy) begin
        mem[sweep_idx] <= '0;
      end else if (wr_accept) begin
        mem[wr_addr_i] <= sum;
      end
    end
  end

  // Non-blocking update of mem gives read-before-write on a shared address.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else if (rd_accept) begin
      rd_valid_o <= 1'b1;
      rd_data_o  <= rd_in_range ? mem[rd_addr_i] : '0;
    end else begin
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_o <= 1'b0;
    end else if (clr_start) begin
      ovf_o <= 1'b0;
    end else if (wr_accept && sum_ovf) begin
      ovf_o <= 1'b1;
    end
  end

endmodule
`default_nettype wire
